bus_sched: RTL and testbench

BUS_SCHED -- requirements
Module: bus_sched

---
 rtl/bus_sched_pkg.sv | 19 +
 rtl/bus_sched_rr_arbiter.sv | 29 ++
 rtl/bus_sched.sv | 145 ++++++++++++++
 tb/tb_bus_sched.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_sched_pkg.sv
// Shared types and constants for the register-to-register bus scheduler.
package bus_sched_pkg;

    localparam int unsigned IDX_W    = 4;
    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned NREG_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    // A register index is usable only if it addresses an existing register.
    function automatic logic idx_ok(input logic [IDX_W-1:0] idx, input int unsigned nreg);
        return 32'(idx) < nreg;
    endfunction

endpackage

// File: rtl/bus_sched_rr_arbiter.sv
// Round-robin request selector: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [PTR_W-1:0] gnt_idx
);

    always_comb begin
        int unsigned idx;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!gnt_valid && req[PTR_W'(idx)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_sched.sv
// Shared DATA-bus transfer scheduler: grants one register move at a time
// (IDLE -> DRIVE settle -> CAPTURE), round-robin across requesters.
module bus_sched
    import bus_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned NREG = NREG_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*IDX_W-1:0] req_src,
    input  logic [NREQ*IDX_W-1:0] req_dst,
    input  logic                 hold,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      err,
    output logic [NREG-1:0]      enable,
    output logic [NREG-1:0]      latch,
    output logic                 busy
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    gnt_q, gnt_d;
    logic [IDX_W-1:0]    src_q, src_d;
    logic [IDX_W-1:0]    dst_q, dst_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic [NREQ-1:0]     err_q, err_d;
    logic [NREG-1:0]     enable_q, enable_d;
    logic [NREG-1:0]     latch_q, latch_d;
    logic                busy_q, busy_d;

    logic                arb_valid;
    logic [PTR_W-1:0]    arb_idx;
    logic [IDX_W-1:0]    arb_src;
    logic [IDX_W-1:0]    arb_dst;

    function automatic logic [NREG-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            v[i] = (32'(idx) == i);
        end
        return v;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
        return (32'(idx) >= NREQ - 1) ? '0 : idx + PTR_W'(1);
    endfunction

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .gnt_valid (arb_valid),
        .gnt_idx   (arb_idx)
    );

    assign arb_src = req_src[32'(arb_idx) * IDX_W +: IDX_W];
    assign arb_dst = req_dst[32'(arb_idx) * IDX_W +: IDX_W];

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            ack_q    <= '0;
            err_q    <= '0;
            enable_q <= '0;
            latch_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            enable_q <= enable_d;
            latch_q  <= latch_d;
            busy_q   <= busy_d;
        end
    end

    // Next state plus the output values that will be visible in that state.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        src_d    = src_q;
        dst_d    = dst_q;
        ack_d    = '0;
        err_d    = '0;
        enable_d = '0;
        latch_d  = '0;
        busy_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!hold && arb_valid) begin
                    gnt_d = arb_idx;
                    src_d = arb_src;
                    dst_d = arb_dst;
                    if (arb_src == arb_dst || !idx_ok(arb_src, NREG) || !idx_ok(arb_dst, NREG)) begin
                        err_d[arb_idx] = 1'b1;
                        ptr_d          = next_ptr(arb_idx);
                    end else begin
                        state_d  = ST_DRIVE;
                        enable_d = onehot(arb_src);
                        busy_d   = 1'b1;
                    end
                end
            end
            ST_DRIVE: begin
                state_d        = ST_CAPTURE;
                enable_d       = onehot(src_q);
                latch_d        = onehot(dst_q);
                ack_d[gnt_q]   = 1'b1;
                busy_d         = 1'b1;
            end
            ST_CAPTURE: begin
                state_d = ST_IDLE;
                ptr_d   = next_ptr(gnt_q);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ack    = ack_q;
    assign err    = err_q;
    assign enable = enable_q;
    assign latch  = latch_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_bus_sched.sv
// Self-checking bench for bus_sched: directed scenarios plus random traffic
// checked against a transaction-level schedule model.
module tb_bus_sched;

    localparam int NREQ = 4;
    localparam int NREG = 16;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*4-1:0] req_src;
    logic [NREQ*4-1:0] req_dst;
    logic              hold;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   err;
    logic [NREG-1:0]   enable;
    logic [NREG-1:0]   latch;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [NREQ-1:0] ack;
        logic [NREQ-1:0] err;
        logic [NREG-1:0] en;
        logic [NREG-1:0] lat;
        logic            busy;
    } out_t;

    out_t q_m[$];
    out_t exp_o;
    int   ptr_m;

    bus_sched #(.NREQ(NREQ), .NREG(NREG)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .req_src (req_src),
        .req_dst (req_dst),
        .hold    (hold),
        .ack     (ack),
        .err     (err),
        .enable  (enable),
        .latch   (latch),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Schedule model: a valid grant queues its drive, capture and recovery cycles.
    task automatic model_edge();
        out_t o;
        o = '0;
        if (reset) begin
            q_m.delete();
            ptr_m = 0;
        end else if (q_m.size() > 0) begin
            o = q_m.pop_front();
        end else if (!hold && req != '0) begin
            int g, s, d;
            out_t cp;
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (ptr_m + k) % NREQ;
                if (g < 0 && req[i]) g = i;
            end
            s = int'(req_src[g*4 +: 4]);
            d = int'(req_dst[g*4 +: 4]);
            ptr_m = (g + 1) % NREQ;
            if (s == d || s >= NREG || d >= NREG) begin
                o.err[g] = 1'b1;
            end else begin
                o.en[s]  = 1'b1;
                o.busy   = 1'b1;
                cp       = o;
                cp.lat[d] = 1'b1;
                cp.ack[g] = 1'b1;
                q_m.push_back(cp);
                q_m.push_back('0);
            end
        end
        exp_o = o;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("ack",    32'(ack),    32'(exp_o.ack));
        chk("err",    32'(err),    32'(exp_o.err));
        chk("enable", 32'(enable), 32'(exp_o.en));
        chk("latch",  32'(latch),  32'(exp_o.lat));
        chk("busy",   32'(busy),   32'(exp_o.busy));
        chk("enable_onehot", 32'($countones(enable) <= 1), 32'd1);
        chk("latch_onehot",  32'($countones(latch) <= 1),  32'd1);
    endtask

    task automatic set_rq(input int i, input logic [3:0] s, input logic [3:0] d);
        req_src[i*4 +: 4] = s;
        req_dst[i*4 +: 4] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        req     = '0;
        req_src = '0;
        req_dst = '0;
        hold    = 1'b0;
        ptr_m   = 0;
        exp_o   = '0;

        // Reset state
        step();
        step();
        chk("reset_busy",   32'(busy),   32'd0);
        chk("reset_enable", 32'(enable), 32'd0);
        reset = 1'b0;

        // Single transfer 3 -> 5
        set_rq(0, 4'd3, 4'd5);
        req = 4'b0001;
        step();
        chk("single_drive_en",  32'(enable), 32'h0008);
        chk("single_drive_lat", 32'(latch),  32'h0000);
        chk("single_drive_busy", 32'(busy),  32'd1);
        step();
        chk("single_cap_en",  32'(enable), 32'h0008);
        chk("single_cap_lat", 32'(latch),  32'h0020);
        chk("single_cap_ack", 32'(ack),    32'h1);
        req = '0;
        step();
        chk("single_done_busy", 32'(busy), 32'd0);

        // Round-robin with all requesters valid
        do_reset();
        for (int i = 0; i < NREQ; i++) set_rq(i, 4'(i), 4'(i + 8));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_order", 32'(enable), 32'(1 << (k % 4)));
            step();
            chk("rr_ack", 32'(ack), 32'(1 << (k % 4)));
            step();
        end
        req = '0;
        step();

        // Rejected grant for requester 2, then requester 3 goes first
        do_reset();
        set_rq(2, 4'd7, 4'd7);
        set_rq(3, 4'd1, 4'd4);
        req = 4'b1100;
        step();
        chk("rej_err",  32'(err),    32'h4);
        chk("rej_en",   32'(enable), 32'h0);
        chk("rej_busy", 32'(busy),   32'd0);
        step();
        chk("rej_next_grant", 32'(enable), 32'h0002);
        req = 4'b0000;
        step();
        step();

        // Hold blocks grants until it falls
        set_rq(1, 4'd6, 4'd2);
        hold = 1'b1;
        req  = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_no_grant", 32'(busy), 32'd0);
        end
        hold = 1'b0;
        step();
        chk("hold_release_grant", 32'(enable), 32'h0040);
        hold = 1'b1;
        step();
        chk("hold_mid_xfer_ack", 32'(ack), 32'h2);
        req  = '0;
        hold = 1'b0;
        step();

        // Reset during DRIVE aborts the transfer
        do_reset();
        set_rq(0, 4'd2, 4'd9);
        set_rq(1, 4'd12, 4'd13);
        req = 4'b0001;
        step();
        chk("abort_drive_en", 32'(enable), 32'h0004);
        reset = 1'b1;
        step();
        chk("abort_en",   32'(enable), 32'h0);
        chk("abort_lat",  32'(latch),  32'h0);
        chk("abort_ack",  32'(ack),    32'h0);
        chk("abort_busy", 32'(busy),   32'd0);
        reset = 1'b0;
        req   = 4'b0011;
        step();
        chk("abort_ptr0", 32'(enable), 32'h0004);
        step();
        chk("abort_lat9", 32'(latch),  32'h0200);
        req = '0;
        step();

        // Request dropped during DRIVE still completes
        do_reset();
        set_rq(1, 4'd4, 4'd6);
        req = 4'b0010;
        step();
        req = 4'b0000;
        set_rq(1, 4'd11, 4'd11);
        step();
        chk("drop_ack", 32'(ack),   32'h2);
        chk("drop_lat", 32'(latch), 32'h0040);
        step();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            req   = 4'($urandom_range(0, 15));
            hold  = ($urandom_range(0, 4) == 0);
            reset = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < NREQ; i++) begin
                logic [3:0] s, d;
                s = 4'($urandom_range(0, 15));
                d = ($urandom_range(0, 4) == 0) ? s : 4'($urandom_range(0, 15));
                set_rq(i, s, d);
            end
            step();
        end
        reset = 1'b0;
        req   = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
